// File: rtl/axi_addr_gate_if.sv
// -----------------------------------------------------------------------------
// axi_addr_gate_if
// Bundles the signals of the address admission stage:
//   s_*              upstream request channel (valid/ready, ID, address, target)
//   m_*              downstream request channel (valid/ready plus head payload)
//   a_*              attempt information for the ordering/outstanding tracker
//   *_stall_i        stall indications returned by the tracker
//   stall_clr_i      clears the stall counter and the sticky timeout flag
//   stall_timeout_o  sticky flag for a head that stayed stalled too long
// Modports:
//   slave  - the gate itself (consumes s_*, produces m_* / a_*)
//   master - the environment around the gate (produces s_*, consumes m_* / a_*)
// -----------------------------------------------------------------------------
interface axi_addr_gate_if #(
    parameter int W_ID   = 6,
    parameter int W_ADDR = 32,
    parameter int W_TGT  = 3
);
    logic              s_valid_i;
    logic              s_ready_o;
    logic [W_ID-1:0]   s_id_i;
    logic [W_ADDR-1:0] s_addr_i;
    logic [W_TGT-1:0]  s_target_slave_i;

    logic              m_valid_o;
    logic              m_ready_i;
    logic [W_ID-1:0]   m_id_o;
    logic [W_ADDR-1:0] m_addr_o;
    logic [W_TGT-1:0]  m_target_slave_o;

    logic              a_valid_o;
    logic              a_ready_o;
    logic [W_ID-1:0]   a_id_o;
    logic [W_TGT-1:0]  a_target_slave_o;

    logic              deadlock_stall_i;
    logic              ost_stall_i;
    logic              stall_clr_i;
    logic              stall_timeout_o;

    modport slave (
        input  s_valid_i, s_id_i, s_addr_i, s_target_slave_i,
        output s_ready_o,
        output m_valid_o, m_id_o, m_addr_o, m_target_slave_o,
        input  m_ready_i,
        output a_valid_o, a_ready_o, a_id_o, a_target_slave_o,
        input  deadlock_stall_i, ost_stall_i, stall_clr_i,
        output stall_timeout_o
    );

    modport master (
        output s_valid_i, s_id_i, s_addr_i, s_target_slave_i,
        input  s_ready_o,
        input  m_valid_o, m_id_o, m_addr_o, m_target_slave_o,
        output m_ready_i,
        input  a_valid_o, a_ready_o, a_id_o, a_target_slave_o,
        output deadlock_stall_i, ost_stall_i, stall_clr_i,
        input  stall_timeout_o
    );
endinterface

// File: rtl/axi_addr_gate.sv
// -----------------------------------------------------------------------------
// axi_addr_gate
// Address-channel admission stage in front of the per-slave-port ordering /
// outstanding tracker. Requests land in a 2-entry skid queue (entry0 = head,
// entry1 = skid); the head is shown to the tracker every cycle and forwarded
// downstream only while the tracker reports no deadlock/outstanding stall.
// Once a head has been offered downstream without being taken it is committed
// and stays valid regardless of stalls until the handshake completes.
// A saturating counter measures consecutive stalled cycles and raises a sticky
// timeout flag once it has reached STALL_MAX_CNT.
//
// Ports:
//   clk_i     clock
//   reset_i   synchronous active-high reset
//   bus       axi_addr_gate_if.slave (upstream, downstream, tracker, stall status)
//   stat_dl_cnt_o / stat_ost_cnt_o  stall statistics (only with the macro below)
//
// Build option: define AXI_ADDR_GATE_STATS_EN to add the two 16-bit saturating
// stall statistics counters and their output ports.
// -----------------------------------------------------------------------------
module axi_addr_gate #(
    parameter int NUM_SLAVE     = 8,
    parameter int W_ID          = 6,
    parameter int W_ADDR        = 32,
    parameter int STALL_MAX_CNT = 1023
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    axi_addr_gate_if.slave       bus
`ifdef AXI_ADDR_GATE_STATS_EN
    ,
    output logic [15:0]          stat_dl_cnt_o,
    output logic [15:0]          stat_ost_cnt_o
`endif
);
    localparam int NUM_SLAVE_LOG2 = $clog2(NUM_SLAVE);
    localparam int W_STALL        = $clog2(STALL_MAX_CNT + 1);
    localparam int W_PL           = NUM_SLAVE_LOG2 + W_ID + W_ADDR;
    localparam logic [W_STALL-1:0] STALL_MAX = W_STALL'(STALL_MAX_CNT);

    // Queue occupancy doubles as the state of the skid queue.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state, w_state_next;
    logic [W_PL-1:0]     r_e0, r_e1, w_e0_next, w_e1_next;
    logic [W_PL-1:0]     w_in;
    logic                r_s_ready;
    logic                r_commit, w_commit_next;
    logic [W_STALL-1:0]  r_stall_cnt, w_stall_cnt_next;
    logic                r_timeout, w_timeout_next;

    logic                w_busy, w_stalled, w_m_valid, w_push, w_pop;

    assign w_in      = {bus.s_target_slave_i, bus.s_id_i, bus.s_addr_i};
    assign w_busy    = (r_state != ST_EMPTY);
    assign w_stalled = bus.deadlock_stall_i | bus.ost_stall_i;
    // A committed head ignores stalls so valid cannot drop before the handshake.
    assign w_m_valid = w_busy & (r_commit | ~w_stalled);
    assign w_push    = bus.s_valid_i & r_s_ready;
    assign w_pop     = w_m_valid & bus.m_ready_i;

    // Queue next-state and payload movement. Input is only ever written into
    // a register, never passed straight to the head outputs.
    always_comb begin
        w_state_next = r_state;
        w_e0_next    = r_e0;
        w_e1_next    = r_e1;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_e0_next    = w_in;
                    w_state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    w_e0_next = w_in;
                end else if (w_push) begin
                    w_e1_next    = w_in;
                    w_state_next = ST_FULL;
                end else if (w_pop) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_e0_next    = r_e1;
                    w_state_next = ST_ONE;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_comb begin
        w_commit_next = r_commit;
        if (w_pop) begin
            w_commit_next = 1'b0;
        end else if (w_m_valid && !bus.m_ready_i) begin
            w_commit_next = 1'b1;
        end

        w_stall_cnt_next = r_stall_cnt;
        if (w_pop || bus.stall_clr_i || !w_busy) begin
            w_stall_cnt_next = '0;
        end else if (!w_m_valid && (r_stall_cnt != STALL_MAX)) begin
            w_stall_cnt_next = r_stall_cnt + 1'b1;
        end

        // Clear has priority over a simultaneous set.
        w_timeout_next = r_timeout | (r_stall_cnt == STALL_MAX);
        if (bus.stall_clr_i) begin
            w_timeout_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= ST_EMPTY;
            r_e0        <= '0;
            r_e1        <= '0;
            r_s_ready   <= 1'b1;
            r_commit    <= 1'b0;
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_e0        <= w_e0_next;
            r_e1        <= w_e1_next;
            // Ready is precomputed from the next occupancy so it is a pure flop.
            r_s_ready   <= (w_state_next != ST_FULL);
            r_commit    <= w_commit_next;
            r_stall_cnt <= w_stall_cnt_next;
            r_timeout   <= w_timeout_next;
        end
    end

    assign bus.s_ready_o        = r_s_ready;
    assign bus.m_valid_o        = w_m_valid;
    assign {bus.m_target_slave_o, bus.m_id_o, bus.m_addr_o} = r_e0;
    assign bus.a_valid_o        = w_busy;
    assign bus.a_ready_o        = w_pop;
    assign bus.a_id_o           = bus.m_id_o;
    assign bus.a_target_slave_o = bus.m_target_slave_o;
    assign bus.stall_timeout_o  = r_timeout;

`ifdef AXI_ADDR_GATE_STATS_EN
    logic [15:0] r_stat_dl, r_stat_ost;
    logic        w_stat_en;

    // Only uncommitted pending heads are really held back by a stall.
    assign w_stat_en = w_busy & ~r_commit;

    always_ff @(posedge clk_i) begin
        if (reset_i || bus.stall_clr_i) begin
            r_stat_dl  <= '0;
            r_stat_ost <= '0;
        end else begin
            if (w_stat_en && bus.deadlock_stall_i && (r_stat_dl != 16'hFFFF)) begin
                r_stat_dl <= r_stat_dl + 16'd1;
            end
            if (w_stat_en && bus.ost_stall_i && (r_stat_ost != 16'hFFFF)) begin
                r_stat_ost <= r_stat_ost + 16'd1;
            end
        end
    end

    assign stat_dl_cnt_o  = r_stat_dl;
    assign stat_ost_cnt_o = r_stat_ost;
`endif
endmodule

// File: tb/tb_axi_addr_gate.sv
// -----------------------------------------------------------------------------
// tb_axi_addr_gate
// Directed bench for axi_addr_gate (STALL_MAX_CNT = 7). A vector table covers
// back-to-back streaming, backpressure, deadlock stall and commit behaviour;
// hand-written sequences cover the stall timeout, reset mid-transfer and, when
// AXI_ADDR_GATE_STATS_EN is defined, the statistics counters.
// -----------------------------------------------------------------------------
module tb_axi_addr_gate;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    axi_addr_gate_if #(.W_ID(6), .W_ADDR(32), .W_TGT(3)) bus ();

`ifdef AXI_ADDR_GATE_STATS_EN
    logic [15:0] stat_dl, stat_ost;
`endif

    axi_addr_gate #(
        .NUM_SLAVE(8), .W_ID(6), .W_ADDR(32), .STALL_MAX_CNT(7)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
`ifdef AXI_ADDR_GATE_STATS_EN
        ,
        .stat_dl_cnt_o  (stat_dl),
        .stat_ost_cnt_o (stat_ost)
`endif
    );

    typedef struct {
        logic       sv;
        logic [5:0] id;
        logic       mr;
        logic       dl;
        logic       ost;
        logic       e_sr;
        logic       e_mv;
        logic       e_av;
        logic       e_ar;
        logic [5:0] e_id;
    } vec_t;

    vec_t vecs [24];

    function automatic logic [31:0] addr_of(input logic [5:0] id);
        return 32'hA500_0000 | {26'd0, id};
    endfunction

    function automatic logic [2:0] tgt_of(input logic [5:0] id);
        return id[2:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sv, input logic [5:0] id, input logic mr,
                         input logic dl, input logic ost);
        bus.s_valid_i        = sv;
        bus.s_id_i           = id;
        bus.s_addr_i         = addr_of(id);
        bus.s_target_slave_i = tgt_of(id);
        bus.m_ready_i        = mr;
        bus.deadlock_stall_i = dl;
        bus.ost_stall_i      = ost;
    endtask

    task automatic chk_head(input string tag, input logic [5:0] id);
        chk({tag, " m_id"},     64'(bus.m_id_o), 64'(id));
        chk({tag, " m_addr"},   64'(bus.m_addr_o), 64'(addr_of(id)));
        chk({tag, " m_target"}, 64'(bus.m_target_slave_o), 64'(tgt_of(id)));
        chk({tag, " a_id"},     64'(bus.a_id_o), 64'(id));
        chk({tag, " a_target"}, 64'(bus.a_target_slave_o), 64'(tgt_of(id)));
    endtask

    initial begin
        //            sv  id    mr  dl  ost  sr  mv  av  ar  head
        vecs[0]  = '{1'b1, 6'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
        vecs[1]  = '{1'b1, 6'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd1};
        vecs[2]  = '{1'b1, 6'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd2};
        vecs[3]  = '{1'b1, 6'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd3};
        vecs[4]  = '{1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd4};
        vecs[5]  = '{1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
        vecs[6]  = '{1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
        vecs[7]  = '{1'b1, 6'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd5};
        vecs[8]  = '{1'b1, 6'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd5};
        vecs[9]  = '{1'b1, 6'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd5};
        vecs[10] = '{1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd6};
        vecs[11] = '{1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
        vecs[12] = '{1'b1, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
        vecs[13] = '{1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd8};
        vecs[14] = '{1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd8};
        vecs[15] = '{1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd8};
        vecs[16] = '{1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
        vecs[17] = '{1'b1, 6'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
        vecs[18] = '{1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd9};
        vecs[19] = '{1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd9};
        vecs[20] = '{1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd9};
        vecs[21] = '{1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd9};
        vecs[22] = '{1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
        vecs[23] = '{1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};

        drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        bus.stall_clr_i = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Table: streaming, backpressure, deadlock stall, commit.
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].sv, vecs[i].id, vecs[i].mr, vecs[i].dl, vecs[i].ost);
            #1;
            $display("vec %0d sv=%0b id=%0d mr=%0b dl=%0b ost=%0b -> sr=%0b mv=%0b av=%0b head=%0d",
                     i, vecs[i].sv, vecs[i].id, vecs[i].mr, vecs[i].dl, vecs[i].ost,
                     bus.s_ready_o, bus.m_valid_o, bus.a_valid_o, bus.m_id_o);
            chk($sformatf("v%0d s_ready", i), 64'(bus.s_ready_o), 64'(vecs[i].e_sr));
            chk($sformatf("v%0d m_valid", i), 64'(bus.m_valid_o), 64'(vecs[i].e_mv));
            chk($sformatf("v%0d a_valid", i), 64'(bus.a_valid_o), 64'(vecs[i].e_av));
            chk($sformatf("v%0d a_ready", i), 64'(bus.a_ready_o), 64'(vecs[i].e_ar));
            chk($sformatf("v%0d timeout", i), 64'(bus.stall_timeout_o), 64'd0);
            if (vecs[i].e_av) begin
                chk_head($sformatf("v%0d", i), vecs[i].e_id);
            end
            tick();
        end

`ifdef AXI_ADDR_GATE_STATS_EN
        // Two uncommitted deadlock cycles; committed ost cycles are not counted.
        chk("stat_dl after table", 64'(stat_dl), 64'd2);
        chk("stat_ost after table", 64'(stat_ost), 64'd0);
`endif

        // Stall timeout: 8 stalled cycles, then sticky, clear, re-arm.
        drive(1'b1, 6'd10, 1'b1, 1'b0, 1'b0);
        #1;
        chk("to push s_ready", 64'(bus.s_ready_o), 64'd1);
        tick();
        drive(1'b0, 6'd0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("to1 cyc%0d timeout", k + 1), 64'(bus.stall_timeout_o), 64'd0);
            chk($sformatf("to1 cyc%0d m_valid", k + 1), 64'(bus.m_valid_o), 64'd0);
            tick();
        end
        #1;
        $display("timeout after 8 stalled cycles = %0b", bus.stall_timeout_o);
        chk("to1 set", 64'(bus.stall_timeout_o), 64'd1);
        tick();
        chk("to1 sticky", 64'(bus.stall_timeout_o), 64'd1);
        bus.stall_clr_i = 1'b1;
        #1;
        chk("to clr cycle", 64'(bus.stall_timeout_o), 64'd1);
        tick();
        bus.stall_clr_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("to2 cyc%0d timeout", k + 1), 64'(bus.stall_timeout_o), 64'd0);
            tick();
        end
        #1;
        $display("timeout re-asserted after clear = %0b", bus.stall_timeout_o);
        chk("to2 set", 64'(bus.stall_timeout_o), 64'd1);
        drive(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("to release m_valid", 64'(bus.m_valid_o), 64'd1);
        chk_head("to release", 6'd10);
        tick();
        chk("to after pop a_valid", 64'(bus.a_valid_o), 64'd0);
        chk("to after pop sticky", 64'(bus.stall_timeout_o), 64'd1);

        // Reset mid-transfer with a full, committed queue and timeout set.
        drive(1'b1, 6'd11, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 6'd12, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst pre s_ready", 64'(bus.s_ready_o), 64'd0);
        chk("rst pre m_valid", 64'(bus.m_valid_o), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        #1;
        $display("after reset: sr=%0b mv=%0b av=%0b to=%0b",
                 bus.s_ready_o, bus.m_valid_o, bus.a_valid_o, bus.stall_timeout_o);
        chk("rst s_ready", 64'(bus.s_ready_o), 64'd1);
        chk("rst m_valid", 64'(bus.m_valid_o), 64'd0);
        chk("rst a_valid", 64'(bus.a_valid_o), 64'd0);
        chk("rst a_ready", 64'(bus.a_ready_o), 64'd0);
        chk("rst timeout", 64'(bus.stall_timeout_o), 64'd0);
        tick();
        chk("rst+1 m_valid", 64'(bus.m_valid_o), 64'd0);

`ifdef AXI_ADDR_GATE_STATS_EN
        // Both stalls for 5 pending cycles, then reset mid-burst.
        chk("stat rst dl", 64'(stat_dl), 64'd0);
        chk("stat rst ost", 64'(stat_ost), 64'd0);
        drive(1'b1, 6'd13, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b0, 6'd0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        $display("stats after 5 cycles: dl=%0d ost=%0d", stat_dl, stat_ost);
        chk("stat dl 5", 64'(stat_dl), 64'd5);
        chk("stat ost 5", 64'(stat_ost), 64'd5);
        drive(1'b1, 6'd14, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b0, 6'd0, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("stat burst rst dl", 64'(stat_dl), 64'd0);
        chk("stat burst rst ost", 64'(stat_ost), 64'd0);
        chk("stat burst rst a_valid", 64'(bus.a_valid_o), 64'd0);
        chk("stat burst rst s_ready", 64'(bus.s_ready_o), 64'd1);
`endif

        drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
